// File: rtl/conv_layer_param.sv
// conv_layer_param: streaming KxK 2-D convolution with N_CH channels, stride, bias, shift, saturation
// Ports: clk; rst_n (synchronous, active-high); valid_in/data_in raster pixel stream (no back-pressure);
//        w_we/w_addr/w_data load signed weights (c*K*K+r*K+col) and biases (N_CH*K*K+c);
//        conv_out (channel c at [c*OUT_BITS +: OUT_BITS], signed), valid_out, frame_done.
// Optional: define CONV_RELU_EN to clamp negative channel outputs to zero.
module conv_layer_param #(
   parameter int IMG_W     = 28,
   parameter int IMG_H     = 28,
   parameter int K         = 5,
   parameter int N_CH      = 3,
   parameter int STRIDE    = 1,
   parameter int DATA_BITS = 8,
   parameter int WGT_BITS  = 8,
   parameter int OUT_BITS  = 12,
   parameter int SHIFT     = 0,
   localparam int AW       = $clog2(N_CH*K*K+N_CH)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       valid_in,
   input  logic [DATA_BITS-1:0]       data_in,
   input  logic                       w_we,
   input  logic [AW-1:0]              w_addr,
   input  logic [WGT_BITS-1:0]        w_data,
   output logic [N_CH*OUT_BITS-1:0]   conv_out,
   output logic                       valid_out,
   output logic                       frame_done
);
   localparam int KK    = K*K;
   localparam int NW    = N_CH*KK+N_CH;
   localparam int L     = (K-1)*IMG_W+K-1;
   localparam int PW    = DATA_BITS+WGT_BITS+1;
   localparam int ACC_W = DATA_BITS+WGT_BITS+$clog2(K*K+1)+1;
   localparam int CW    = $clog2(IMG_W+1);
   localparam int RW    = $clog2(IMG_H+1);
   localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((1 << (OUT_BITS-1)) - 1);
   localparam logic signed [ACC_W-1:0] MINV = ~MAXV;

   logic [CW-1:0]                r_col;
   logic [RW-1:0]                r_row;
   logic [L*DATA_BITS-1:0]       r_sr;
   logic [(L+1)*DATA_BITS-1:0]   w_tap;
   logic [DATA_BITS-1:0]         w_win [KK];
   logic signed [WGT_BITS-1:0]   r_w [NW];
   logic signed [PW-1:0]         r_prod [N_CH][KK];
   logic signed [WGT_BITS-1:0]   r_b [N_CH];
   logic signed [ACC_W-1:0]      w_acc, w_sh;
   logic signed [OUT_BITS-1:0]   w_y [N_CH];
   logic                         r_s1_v, r_s1_fd, w_col_end, w_row_end, w_win_v;

   // Tap 0 is the pixel being accepted; tap n is the pixel accepted n pixels earlier.
   assign w_tap     = {r_sr, data_in};
   assign w_col_end = r_col == CW'(IMG_W-1);
   assign w_row_end = r_row == RW'(IMG_H-1);
   assign w_win_v   = valid_in && r_row >= RW'(K-1) && r_col >= CW'(K-1) &&
                      (r_row - RW'(K-1)) % RW'(STRIDE) == '0 && (r_col - CW'(K-1)) % CW'(STRIDE) == '0;

   for (genvar i = 0; i < K; i++) begin : g_r
      for (genvar j = 0; j < K; j++) begin : g_c
         assign w_win[i*K+j] = w_tap[((K-1-i)*IMG_W+K-1-j)*DATA_BITS +: DATA_BITS];
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         r_col      <= '0;
         r_row      <= '0;
         r_s1_v     <= 1'b0;
         r_s1_fd    <= 1'b0;
         valid_out  <= 1'b0;
         frame_done <= 1'b0;
         conv_out   <= '0;
         for (int i = 0; i < NW; i++) r_w[i] <= '0;
      end else begin
         if (valid_in) begin
            r_col <= w_col_end ? '0 : r_col + 1'b1;
            if (w_col_end) r_row <= w_row_end ? '0 : r_row + 1'b1;
         end
         if (w_we && 32'(w_addr) < NW) r_w[w_addr] <= w_data;
         r_s1_v     <= w_win_v;
         r_s1_fd    <= valid_in && w_col_end && w_row_end;
         valid_out  <= r_s1_v;
         frame_done <= r_s1_fd;
         if (r_s1_v)
            for (int c = 0; c < N_CH; c++) conv_out[c*OUT_BITS +: OUT_BITS] <= w_y[c];
      end
   end

   // Products and bias are captured at the accepting edge, so a simultaneous weight write
   // only reaches later pixels.
   always_ff @(posedge clk) begin
      if (valid_in) r_sr <= w_tap[L*DATA_BITS-1:0];
      for (int c = 0; c < N_CH; c++) begin
         r_b[c] <= r_w[N_CH*KK+c];
         for (int k = 0; k < KK; k++)
            r_prod[c][k] <= PW'($signed({1'b0, w_win[k]})) * PW'(r_w[c*KK+k]);
      end
   end

   always_comb begin
      w_acc = '0;
      w_sh  = '0;
      for (int c = 0; c < N_CH; c++) begin
         w_acc = ACC_W'(r_b[c]);
         for (int k = 0; k < KK; k++) w_acc = w_acc + ACC_W'(r_prod[c][k]);
         w_sh   = w_acc >>> SHIFT;
         w_y[c] = w_sh > MAXV ? MAXV[OUT_BITS-1:0] : w_sh < MINV ? MINV[OUT_BITS-1:0] : w_sh[OUT_BITS-1:0];
`ifdef CONV_RELU_EN
         w_y[c] = w_y[c][OUT_BITS-1] ? '0 : w_y[c];
`endif
      end
   end
endmodule

// File: tb/tb_conv_layer_param.sv
// tb_conv_layer_param: scoreboard bench for an 8x8, K=3, 2-channel layer at stride 1 and stride 2
module tb_conv_layer_param;
`ifdef CONV_RELU_EN
   localparam int NEG = 0;
`else
   localparam int NEG = -2048;
`endif
   typedef struct {bit v; bit fd; int c0; int c1;} exp_t;

   logic        clk = 1'b0, rst_n = 1'b1, valid_in = 1'b0, w_we = 1'b0;
   logic [7:0]  data_in = '0, w_data = '0;
   logic [4:0]  w_addr = '0;
   logic [23:0] co1, co2;
   logic        vo1, vo2, fd1, fd2;
   exp_t        q1[$], q2[$];
   int          n_chk = 0, n_fail = 0, n_fd1 = 0, n_fd2 = 0;

   always #5 clk = ~clk;

   conv_layer_param #(.IMG_W(8), .IMG_H(8), .K(3), .N_CH(2), .STRIDE(1), .DATA_BITS(8),
                      .WGT_BITS(8), .OUT_BITS(12), .SHIFT(0)) u_s1 (
      .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_in(data_in), .w_we(w_we),
      .w_addr(w_addr), .w_data(w_data), .conv_out(co1), .valid_out(vo1), .frame_done(fd1));

   conv_layer_param #(.IMG_W(8), .IMG_H(8), .K(3), .N_CH(2), .STRIDE(2), .DATA_BITS(8),
                      .WGT_BITS(8), .OUT_BITS(12), .SHIFT(0)) u_s2 (
      .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_in(data_in), .w_we(w_we),
      .w_addr(w_addr), .w_data(w_data), .conv_out(co2), .valid_out(vo2), .frame_done(fd2));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cmp(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_out(input string nm, input exp_t e, input logic v, input logic fd, input logic [23:0] co);
      cmp({nm, " valid_out"}, int'(v), int'(e.v));
      cmp({nm, " frame_done"}, int'(fd), int'(e.fd));
      if (e.v) begin
         cmp({nm, " ch0"}, int'($signed(co[11:0])), e.c0);
         cmp({nm, " ch1"}, int'($signed(co[23:12])), e.c1);
      end
   endtask

   always @(negedge clk) begin
      n_fd1 += int'(fd1);
      if (vo1 || fd1) begin
         if (q1.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL s1 unexpected output: got v=%0b fd=%0b, expected none", vo1, fd1);
         end else chk_out("s1", q1.pop_front(), vo1, fd1, co1);
      end
   end

   always @(negedge clk) begin
      n_fd2 += int'(fd2);
      if (vo2 || fd2) begin
         if (q2.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL s2 unexpected output: got v=%0b fd=%0b, expected none", vo2, fd2);
         end else chk_out("s2", q2.pop_front(), vo2, fd2, co2);
      end
   end

   task automatic wr(input int a, input int d);
      w_we   = 1'b1;
      w_addr = 5'(a);
      w_data = 8'(d);
      tick();
      w_we   = 1'b0;
   endtask

   // pc>=0: constant pixel pc, else ramp row*8+col. Expected ch0 = m0*centre_of_ramp + a0, ch1 = e1.
   task automatic send_frame(input int pc, input int m0, input int a0, input int e1, input bit gaps,
                             input int npix, input int wr_at, input int wa, input int wd);
      int r, c, e0;
      for (int p = 0; p < npix; p++) begin
         r  = p / 8;
         c  = p % 8;
         e0 = m0 * ((r-1)*8 + (c-1)) + a0;
         if (gaps) repeat ($urandom_range(0, 2)) tick();
         valid_in = 1'b1;
         data_in  = 8'(pc >= 0 ? pc : p);
         if (p == wr_at) begin
            w_we   = 1'b1;
            w_addr = 5'(wa);
            w_data = 8'(wd);
         end
         if (r >= 2 && c >= 2) q1.push_back('{1'b1, p == 63, e0, e1});
         if (r >= 2 && c >= 2 && r % 2 == 0 && c % 2 == 0) q2.push_back('{1'b1, 1'b0, e0, e1});
         if (p == 63) q2.push_back('{1'b0, 1'b1, 0, 0});
         tick();
         valid_in = 1'b0;
         w_we     = 1'b0;
      end
   endtask

   initial begin
      repeat (2) tick();
      rst_n = 1'b0;
      cmp("reset s1 valid_out", int'(vo1), 0);
      cmp("reset s1 conv_out", int'(co1), 0);
      cmp("reset s1 frame_done", int'(fd1), 0);
      cmp("reset s2 valid_out", int'(vo2), 0);
      cmp("reset s2 conv_out", int'(co2), 0);
      for (int a = 0; a < 18; a++) wr(a, 1);
      send_frame(1, 0, 9, 9, 1'b0, 64, -1, 0, 0);
      for (int a = 0; a < 18; a++) wr(a, 127);
      send_frame(255, 0, 2047, 2047, 1'b0, 64, -1, 0, 0);
      for (int a = 0; a < 18; a++) wr(a, -128);
      send_frame(255, 0, NEG, NEG, 1'b0, 64, -1, 0, 0);
      for (int a = 0; a < 18; a++) wr(a, int'(a == 4));
      wr(19, 5);
      send_frame(-1, 1, 0, 5, 1'b0, 64, -1, 0, 0);
      send_frame(-1, 1, 0, 5, 1'b1, 64, 63, 4, 3);
      send_frame(-1, 3, 0, 5, 1'b0, 64, -1, 0, 0);
      send_frame(1, 0, 3, 5, 1'b0, 30, -1, 0, 0);
      rst_n  = 1'b1;
      w_we   = 1'b1;
      w_addr = 5'd4;
      w_data = 8'd50;
      tick();
      rst_n = 1'b0;
      w_we  = 1'b0;
      q1.delete();
      q2.delete();
      cmp("mid-frame reset s1 valid_out", int'(vo1), 0);
      cmp("mid-frame reset s1 conv_out", int'(co1), 0);
      cmp("mid-frame reset s2 valid_out", int'(vo2), 0);
      cmp("mid-frame reset s2 conv_out", int'(co2), 0);
      for (int a = 20; a < 32; a++) wr(a, 7);
      send_frame(9, 0, 0, 0, 1'b0, 64, -1, 0, 0);
      for (int i = 0; i < 10 && (q1.size() != 0 || q2.size() != 0); i++) tick();
      cmp("s1 outstanding expectations", q1.size(), 0);
      cmp("s2 outstanding expectations", q2.size(), 0);
      cmp("s1 frame_done count", n_fd1, 7);
      cmp("s2 frame_done count", n_fd2, 7);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
